ibex_wb_queue: RTL and testbench

- Parametrised writeback stage: a Depth-entry in-order queue between ID/EX and the register file.
- Allows several loads/stores to be outstanding, instead of a single writeback slot.
- Completes entries strictly in order and drives the RF write port.
- Gives ID/EX per-operand forwarding and hazard information by searching all valid entries.

---
 rtl/ibex_wb_queue.sv | 202 ++++++++++++++++++++
 tb/tb_ibex_wb_queue.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ibex_wb_queue.sv
`default_nettype none
// ============================================================================
// Module   : ibex_wb_queue
// Brief    : Depth-entry in-order writeback queue with operand forwarding and
//            load-hazard detection. Optional stall counter: IBEX_WB_QUEUE_PERF_EN
// Revision : 1.0 - initial release
// ============================================================================

package ibex_pkg;
    typedef enum logic [1:0] {
        WB_INSTR_LOAD  = 2'b00,
        WB_INSTR_STORE = 2'b01,
        WB_INSTR_OTHER = 2'b10
    } wb_instr_type_e;
endpackage

module ibex_wb_queue
    import ibex_pkg::*;
#(
    parameter int unsigned Depth = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       en_wb_i,
    input  wb_instr_type_e             instr_type_wb_i,
    input  logic [31:0]                pc_id_i,
    input  logic [4:0]                 rf_waddr_id_i,
    input  logic [31:0]                rf_wdata_id_i,
    input  logic                       rf_we_id_i,
    input  logic [31:0]                rf_wdata_lsu_i,
    input  logic                       rf_we_lsu_i,
    input  logic                       lsu_data_valid_i,
    input  logic [4:0]                 rf_raddr_a_i,
    input  logic [4:0]                 rf_raddr_b_i,
    output logic                       fwd_a_valid_o,
    output logic                       fwd_b_valid_o,
    output logic [31:0]                fwd_a_data_o,
    output logic [31:0]                fwd_b_data_o,
    output logic                       hazard_a_o,
    output logic                       hazard_b_o,
    output logic                       ready_wb_o,
    output logic [$clog2(Depth+1)-1:0] occupancy_o,
    output logic                       outstanding_load_wb_o,
    output logic                       outstanding_store_wb_o,
    output logic [31:0]                pc_wb_o,
    output logic [4:0]                 rf_waddr_wb_o,
    output logic [31:0]                rf_wdata_wb_o,
    output logic                       rf_we_wb_o,
`ifdef IBEX_WB_QUEUE_PERF_EN
    output logic [31:0]                stall_cnt_o,
`endif
    output logic                       instr_done_wb_o
);

    localparam int unsigned PTR_W = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned OCC_W = $clog2(Depth + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(Depth - 1);
    localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(Depth);

    typedef struct packed {
        logic        valid;
        logic        hazard;
        logic [31:0] data;
    } fwd_t;

    logic [Depth-1:0] entry_valid;
    logic [Depth-1:0] entry_we;
    logic [4:0]       entry_waddr [Depth];
    logic [31:0]      entry_wdata [Depth];
    wb_instr_type_e   entry_type  [Depth];
    logic [31:0]      entry_pc    [Depth];

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [OCC_W-1:0] occupancy;

    logic head_valid;
    logic head_is_other;
    logic head_done;
    logic enq;
    logic rf_from_queue;
    fwd_t fwd_a;
    fwd_t fwd_b;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == LAST_PTR) ? '0 : ptr + 1'b1;
    endfunction

    assign head_valid    = entry_valid[rd_ptr];
    assign head_is_other = (entry_type[rd_ptr] == WB_INSTR_OTHER);
    assign head_done     = head_valid & (head_is_other | lsu_data_valid_i);
    assign ready_wb_o    = (occupancy < FULL_OCC) | head_done;
    assign enq           = en_wb_i & ready_wb_o;

    // Retire clears before enqueue sets, so Depth==1 can swap its only slot.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            entry_valid <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            occupancy   <= '0;
        end else begin
            if (head_done) begin
                entry_valid[rd_ptr] <= 1'b0;
                rd_ptr              <= next_ptr(rd_ptr);
            end
            if (enq) begin
                entry_valid[wr_ptr] <= 1'b1;
                wr_ptr              <= next_ptr(wr_ptr);
            end
            case ({enq, head_done})
                2'b10:   occupancy <= occupancy + 1'b1;
                2'b01:   occupancy <= occupancy - 1'b1;
                default: occupancy <= occupancy;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (enq) begin
            entry_we[wr_ptr]    <= rf_we_id_i;
            entry_waddr[wr_ptr] <= rf_waddr_id_i;
            entry_wdata[wr_ptr] <= rf_wdata_id_i;
            entry_type[wr_ptr]  <= instr_type_wb_i;
            entry_pc[wr_ptr]    <= pc_id_i;
        end
    end

    // Walk oldest to youngest so the last hit is the youngest producer.
    function automatic fwd_t fwd_lookup(input logic [4:0] raddr);
        fwd_t             res;
        logic [PTR_W-1:0] p;
        res = '0;
        p   = rd_ptr;
        for (int unsigned i = 0; i < Depth; i++) begin
            if (entry_valid[p] && (raddr != 5'd0) && (entry_waddr[p] == raddr) &&
                (entry_we[p] || (entry_type[p] == WB_INSTR_LOAD))) begin
                res.hazard = (entry_type[p] == WB_INSTR_LOAD);
                res.valid  = (entry_type[p] == WB_INSTR_OTHER);
                res.data   = (entry_type[p] == WB_INSTR_OTHER) ? entry_wdata[p] : 32'd0;
            end
            p = next_ptr(p);
        end
        return res;
    endfunction

    always_comb begin
        fwd_a = fwd_lookup(rf_raddr_a_i);
        fwd_b = fwd_lookup(rf_raddr_b_i);
    end

    assign fwd_a_valid_o = fwd_a.valid;
    assign fwd_a_data_o  = fwd_a.data;
    assign hazard_a_o    = fwd_a.hazard;
    assign fwd_b_valid_o = fwd_b.valid;
    assign fwd_b_data_o  = fwd_b.data;
    assign hazard_b_o    = fwd_b.hazard;

    always_comb begin
        outstanding_load_wb_o  = 1'b0;
        outstanding_store_wb_o = 1'b0;
        for (int unsigned i = 0; i < Depth; i++) begin
            if (entry_valid[i] && (entry_type[i] == WB_INSTR_LOAD)) begin
                outstanding_load_wb_o = 1'b1;
            end
            if (entry_valid[i] && (entry_type[i] == WB_INSTR_STORE)) begin
                outstanding_store_wb_o = 1'b1;
            end
        end
    end

    // The LSU write path is the fallback; a queued OTHER result never coincides with it.
    assign rf_from_queue   = head_valid & head_is_other & entry_we[rd_ptr];
    assign rf_we_wb_o      = rf_from_queue ? 1'b1 : rf_we_lsu_i;
    assign rf_wdata_wb_o   = rf_from_queue ? entry_wdata[rd_ptr] : rf_wdata_lsu_i;
    assign rf_waddr_wb_o   = head_valid ? entry_waddr[rd_ptr] : rf_waddr_id_i;
    assign pc_wb_o         = head_valid ? entry_pc[rd_ptr] : 32'd0;
    assign instr_done_wb_o = head_done;
    assign occupancy_o     = occupancy;

`ifdef IBEX_WB_QUEUE_PERF_EN
    logic [31:0] stall_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt <= '0;
        end else if (en_wb_i && !ready_wb_o && !(&stall_cnt)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    assign stall_cnt_o = stall_cnt;
`endif

    lsu_valid_needs_mem_head: assert property (@(posedge clk_i) disable iff (!rst_ni)
        lsu_data_valid_i |-> (head_valid && !head_is_other));

    lsu_we_needs_load_head: assert property (@(posedge clk_i) disable iff (!rst_ni)
        rf_we_lsu_i |-> (head_valid && (entry_type[rd_ptr] == WB_INSTR_LOAD)));

endmodule
`default_nettype wire

// File: tb/tb_ibex_wb_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_ibex_wb_queue
// Brief    : Scoreboard bench for ibex_wb_queue, Depth=2 and Depth=4 instances.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ibex_wb_queue;
    import ibex_pkg::*;

    typedef struct packed {
        logic [4:0]  waddr;
        logic        we;
        logic [31:0] data;
        logic [31:0] pc;
    } exp_t;

    logic           clk;
    logic           rst_n       [2];
    logic           en          [2];
    wb_instr_type_e typ         [2];
    logic [31:0]    pc_id       [2];
    logic [4:0]     waddr_id    [2];
    logic [31:0]    wdata_id    [2];
    logic           we_id       [2];
    logic [31:0]    wdata_lsu   [2];
    logic           we_lsu      [2];
    logic           lsu_valid   [2];
    logic [4:0]     raddr_a     [2];
    logic [4:0]     raddr_b     [2];
    logic           fwd_a_valid [2];
    logic           fwd_b_valid [2];
    logic [31:0]    fwd_a_data  [2];
    logic [31:0]    fwd_b_data  [2];
    logic           hazard_a    [2];
    logic           hazard_b    [2];
    logic           ready       [2];
    logic [2:0]     occ         [2];
    logic [1:0]     occ2;
    logic [2:0]     occ4;
    logic           out_load    [2];
    logic           out_store   [2];
    logic [31:0]    pc_wb       [2];
    logic [4:0]     rf_waddr    [2];
    logic [31:0]    rf_wdata    [2];
    logic           rf_we       [2];
    logic           done        [2];
`ifdef IBEX_WB_QUEUE_PERF_EN
    logic [31:0]    stall_cnt   [2];
`endif

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_q0[$];
    exp_t exp_q1[$];
    exp_t mon_e;

    assign occ[0] = {1'b0, occ2};
    assign occ[1] = occ4;

    ibex_wb_queue #(.Depth(2)) u_dut2 (
        .clk_i(clk), .rst_ni(rst_n[0]), .en_wb_i(en[0]), .instr_type_wb_i(typ[0]),
        .pc_id_i(pc_id[0]), .rf_waddr_id_i(waddr_id[0]), .rf_wdata_id_i(wdata_id[0]),
        .rf_we_id_i(we_id[0]), .rf_wdata_lsu_i(wdata_lsu[0]), .rf_we_lsu_i(we_lsu[0]),
        .lsu_data_valid_i(lsu_valid[0]), .rf_raddr_a_i(raddr_a[0]), .rf_raddr_b_i(raddr_b[0]),
        .fwd_a_valid_o(fwd_a_valid[0]), .fwd_b_valid_o(fwd_b_valid[0]),
        .fwd_a_data_o(fwd_a_data[0]), .fwd_b_data_o(fwd_b_data[0]),
        .hazard_a_o(hazard_a[0]), .hazard_b_o(hazard_b[0]), .ready_wb_o(ready[0]),
        .occupancy_o(occ2), .outstanding_load_wb_o(out_load[0]),
        .outstanding_store_wb_o(out_store[0]), .pc_wb_o(pc_wb[0]),
        .rf_waddr_wb_o(rf_waddr[0]), .rf_wdata_wb_o(rf_wdata[0]), .rf_we_wb_o(rf_we[0]),
`ifdef IBEX_WB_QUEUE_PERF_EN
        .stall_cnt_o(stall_cnt[0]),
`endif
        .instr_done_wb_o(done[0])
    );

    ibex_wb_queue #(.Depth(4)) u_dut4 (
        .clk_i(clk), .rst_ni(rst_n[1]), .en_wb_i(en[1]), .instr_type_wb_i(typ[1]),
        .pc_id_i(pc_id[1]), .rf_waddr_id_i(waddr_id[1]), .rf_wdata_id_i(wdata_id[1]),
        .rf_we_id_i(we_id[1]), .rf_wdata_lsu_i(wdata_lsu[1]), .rf_we_lsu_i(we_lsu[1]),
        .lsu_data_valid_i(lsu_valid[1]), .rf_raddr_a_i(raddr_a[1]), .rf_raddr_b_i(raddr_b[1]),
        .fwd_a_valid_o(fwd_a_valid[1]), .fwd_b_valid_o(fwd_b_valid[1]),
        .fwd_a_data_o(fwd_a_data[1]), .fwd_b_data_o(fwd_b_data[1]),
        .hazard_a_o(hazard_a[1]), .hazard_b_o(hazard_b[1]), .ready_wb_o(ready[1]),
        .occupancy_o(occ4), .outstanding_load_wb_o(out_load[1]),
        .outstanding_store_wb_o(out_store[1]), .pc_wb_o(pc_wb[1]),
        .rf_waddr_wb_o(rf_waddr[1]), .rf_wdata_wb_o(rf_wdata[1]), .rf_we_wb_o(rf_we[1]),
`ifdef IBEX_WB_QUEUE_PERF_EN
        .stall_cnt_o(stall_cnt[1]),
`endif
        .instr_done_wb_o(done[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endfunction

    function automatic void push(input int d, input exp_t e);
        if (d == 0) exp_q0.push_back(e);
        else        exp_q1.push_back(e);
    endfunction

    function automatic void cmp_retire(input int d, input exp_t e);
        chk($sformatf("retire%0d waddr", d), {27'd0, rf_waddr[d]}, {27'd0, e.waddr});
        chk($sformatf("retire%0d we", d), {31'd0, rf_we[d]}, {31'd0, e.we});
        if (e.we) chk($sformatf("retire%0d wdata", d), rf_wdata[d], e.data);
        chk($sformatf("retire%0d pc", d), pc_wb[d], e.pc);
    endfunction

    // Monitor: every retirement is matched against the oldest expected entry.
    always @(negedge clk) begin
        if (rst_n[0] && done[0]) begin
            if (exp_q0.size() == 0) chk("retire0 unexpected", 32'd1, 32'd0);
            else begin
                mon_e = exp_q0.pop_front();
                cmp_retire(0, mon_e);
            end
        end
        if (rst_n[1] && done[1]) begin
            if (exp_q1.size() == 0) chk("retire1 unexpected", 32'd1, 32'd0);
            else begin
                mon_e = exp_q1.pop_front();
                cmp_retire(1, mon_e);
            end
        end
    end

    task automatic set_fields(input int d, input wb_instr_type_e t, input logic [4:0] a,
                              input logic [31:0] wd, input logic we, input logic [31:0] pcv,
                              input logic [31:0] ed, input logic ewe);
        exp_t e;
        en[d] = 1'b1; typ[d] = t; waddr_id[d] = a; wdata_id[d] = wd; we_id[d] = we; pc_id[d] = pcv;
        e.waddr = a; e.we = ewe; e.data = ed; e.pc = pcv;
        push(d, e);
    endtask

    task automatic enq(input int d, input wb_instr_type_e t, input logic [4:0] a,
                       input logic [31:0] wd, input logic we, input logic [31:0] pcv,
                       input logic [31:0] ed, input logic ewe);
        set_fields(d, t, a, wd, we, pcv, ed, ewe);
        @(posedge clk); #1;
        en[d] = 1'b0;
    endtask

    task automatic lsu_pulse(input int d, input logic we, input logic [31:0] data);
        lsu_valid[d] = 1'b1; we_lsu[d] = we; wdata_lsu[d] = data;
        @(posedge clk); #1;
        lsu_valid[d] = 1'b0; we_lsu[d] = 1'b0; wdata_lsu[d] = 32'd0;
    endtask

    task automatic drain(input int d);
        for (int i = 0; i < 12 && occ[d] != 3'd0; i++) begin
            @(posedge clk); #1;
        end
        chk($sformatf("drain%0d occupancy", d), {29'd0, occ[d]}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst_n[d] = 1'b0; en[d] = 1'b0; typ[d] = WB_INSTR_OTHER; pc_id[d] = 32'd0;
            waddr_id[d] = 5'd0; wdata_id[d] = 32'd0; we_id[d] = 1'b0; wdata_lsu[d] = 32'd0;
            we_lsu[d] = 1'b0; lsu_valid[d] = 1'b0; raddr_a[d] = 5'd0; raddr_b[d] = 5'd0;
        end
        repeat (3) @(posedge clk);
        #1;
        rst_n[0] = 1'b1; rst_n[1] = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("reset occupancy", {29'd0, occ[d]}, 32'd0);
            chk("reset ready", {31'd0, ready[d]}, 32'd1);
            chk("reset rf_we", {31'd0, rf_we[d]}, 32'd0);
            chk("reset done", {31'd0, done[d]}, 32'd0);
            chk("reset out_load", {31'd0, out_load[d]}, 32'd0);
            chk("reset pc_wb", pc_wb[d], 32'd0);
        end
        waddr_id[0] = 5'd9;
        #1 chk("empty waddr passthrough", {27'd0, rf_waddr[0]}, 32'd9);
        waddr_id[0] = 5'd0;

        // Single OTHER: no same-cycle bypass, retires the following cycle.
        @(posedge clk); #1;
        set_fields(0, WB_INSTR_OTHER, 5'd5, 32'h11, 1'b1, 32'h100, 32'h11, 1'b1);
        #1;
        chk("no bypass done", {31'd0, done[0]}, 32'd0);
        chk("no bypass rf_we", {31'd0, rf_we[0]}, 32'd0);
        @(posedge clk); #1;
        en[0] = 1'b0;
        chk("A occupancy 1", {29'd0, occ[0]}, 32'd1);
        @(posedge clk); #1;
        chk("A occupancy 0", {29'd0, occ[0]}, 32'd0);

        // LOAD blocks an OTHER behind it.
        enq(0, WB_INSTR_LOAD, 5'd3, 32'd0, 1'b0, 32'h200, 32'hAB, 1'b1);
        enq(0, WB_INSTR_OTHER, 5'd4, 32'h22, 1'b1, 32'h204, 32'h22, 1'b1);
        chk("B occupancy full", {29'd0, occ[0]}, 32'd2);
        chk("B out_load", {31'd0, out_load[0]}, 32'd1);
        chk("B out_store", {31'd0, out_store[0]}, 32'd0);
        raddr_a[0] = 5'd3; raddr_b[0] = 5'd4;
        #1;
        chk("B hazard_a", {31'd0, hazard_a[0]}, 32'd1);
        chk("B fwd_a_valid", {31'd0, fwd_a_valid[0]}, 32'd0);
        chk("B fwd_b_valid", {31'd0, fwd_b_valid[0]}, 32'd1);
        chk("B fwd_b_data", fwd_b_data[0], 32'h22);
        chk("B hazard_b", {31'd0, hazard_b[0]}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            chk("B ready while full", {31'd0, ready[0]}, 32'd0);
            @(posedge clk); #1;
        end
        raddr_a[0] = 5'd0; raddr_b[0] = 5'd0;
        lsu_valid[0] = 1'b1; we_lsu[0] = 1'b1; wdata_lsu[0] = 32'hAB;
        #1 chk("B ready on head done", {31'd0, ready[0]}, 32'd1);
        @(posedge clk); #1;
        lsu_valid[0] = 1'b0; we_lsu[0] = 1'b0; wdata_lsu[0] = 32'd0;
        @(posedge clk); #1;
        chk("B occupancy empty", {29'd0, occ[0]}, 32'd0);
        chk("B out_load cleared", {31'd0, out_load[0]}, 32'd0);

        // Full queue: head retires while a new entry is enqueued.
        enq(0, WB_INSTR_LOAD, 5'd8, 32'd0, 1'b0, 32'h300, 32'h88, 1'b1);
        enq(0, WB_INSTR_OTHER, 5'd9, 32'h99, 1'b1, 32'h304, 32'h99, 1'b1);
        chk("C ready full", {31'd0, ready[0]}, 32'd0);
        lsu_valid[0] = 1'b1; we_lsu[0] = 1'b1; wdata_lsu[0] = 32'h88;
        set_fields(0, WB_INSTR_OTHER, 5'd10, 32'hAA, 1'b1, 32'h308, 32'hAA, 1'b1);
        #1 chk("C ready with retire", {31'd0, ready[0]}, 32'd1);
        @(posedge clk); #1;
        en[0] = 1'b0; lsu_valid[0] = 1'b0; we_lsu[0] = 1'b0; wdata_lsu[0] = 32'd0;
        chk("C occupancy stays 2", {29'd0, occ[0]}, 32'd2);
        drain(0);

        // STORE retires on LSU response without an RF write.
        enq(0, WB_INSTR_STORE, 5'd2, 32'd0, 1'b0, 32'h400, 32'd0, 1'b0);
        chk("E out_store", {31'd0, out_store[0]}, 32'd1);
        chk("E out_load", {31'd0, out_load[0]}, 32'd0);
        lsu_pulse(0, 1'b0, 32'd0);
        chk("E out_store cleared", {31'd0, out_store[0]}, 32'd0);
        drain(0);

`ifdef IBEX_WB_QUEUE_PERF_EN
        enq(0, WB_INSTR_LOAD, 5'd11, 32'd0, 1'b0, 32'h500, 32'h5, 1'b1);
        enq(0, WB_INSTR_OTHER, 5'd12, 32'h12, 1'b1, 32'h504, 32'h12, 1'b1);
        en[0] = 1'b1; typ[0] = WB_INSTR_OTHER; waddr_id[0] = 5'd13;
        repeat (6) @(posedge clk);
        #1;
        en[0] = 1'b0;
        chk("perf stall_cnt", stall_cnt[0], 32'd6);
        lsu_pulse(0, 1'b1, 32'h5);
        drain(0);
`endif

        // Depth 4: youngest-match forwarding, x0 exclusion, load hazard.
        enq(1, WB_INSTR_LOAD, 5'd1, 32'd0, 1'b0, 32'h600, 32'h31, 1'b1);
        enq(1, WB_INSTR_OTHER, 5'd7, 32'h1, 1'b1, 32'h604, 32'h1, 1'b1);
        enq(1, WB_INSTR_OTHER, 5'd7, 32'h2, 1'b1, 32'h608, 32'h2, 1'b1);
        raddr_a[1] = 5'd7; raddr_b[1] = 5'd0;
        #1;
        chk("D occupancy 3", {29'd0, occ[1]}, 32'd3);
        chk("D fwd_a_valid", {31'd0, fwd_a_valid[1]}, 32'd1);
        chk("D fwd_a_data youngest", fwd_a_data[1], 32'h2);
        chk("D hazard_a none", {31'd0, hazard_a[1]}, 32'd0);
        chk("D fwd_b_valid x0", {31'd0, fwd_b_valid[1]}, 32'd0);
        chk("D hazard_b x0", {31'd0, hazard_b[1]}, 32'd0);
        chk("D fwd_b_data x0", fwd_b_data[1], 32'd0);
        raddr_b[1] = 5'd1;
        #1;
        chk("D hazard_b load", {31'd0, hazard_b[1]}, 32'd1);
        chk("D fwd_b_valid load", {31'd0, fwd_b_valid[1]}, 32'd0);
        raddr_b[1] = 5'd0;
        @(posedge clk); #1;
        enq(1, WB_INSTR_LOAD, 5'd7, 32'd0, 1'b0, 32'h60C, 32'd0, 1'b1);
        chk("D hazard_a youngest load", {31'd0, hazard_a[1]}, 32'd1);
        chk("D fwd_a_valid youngest load", {31'd0, fwd_a_valid[1]}, 32'd0);
        chk("D ready full", {31'd0, ready[1]}, 32'd0);
        lsu_pulse(1, 1'b1, 32'h31);
        repeat (2) @(posedge clk);
        #1;
        chk("D occupancy load left", {29'd0, occ[1]}, 32'd1);
        chk("D hazard_a remains", {31'd0, hazard_a[1]}, 32'd1);
        enq(1, WB_INSTR_OTHER, 5'd0, 32'h77, 1'b1, 32'h610, 32'h77, 1'b1);
        #1;
        chk("D x0 entry fwd_b_valid", {31'd0, fwd_b_valid[1]}, 32'd0);
        chk("D x0 entry hazard_b", {31'd0, hazard_b[1]}, 32'd0);
        enq(1, WB_INSTR_OTHER, 5'd9, 32'h9, 1'b1, 32'h614, 32'h9, 1'b1);
        chk("D occupancy before reset", {29'd0, occ[1]}, 32'd3);
        chk("D out_load before reset", {31'd0, out_load[1]}, 32'd1);

        // Asynchronous reset mid-cycle drops all pending entries.
        #2;
        rst_n[1] = 1'b0;
        exp_q1.delete();
        #1;
        chk("R occupancy", {29'd0, occ[1]}, 32'd0);
        chk("R rf_we", {31'd0, rf_we[1]}, 32'd0);
        chk("R out_load", {31'd0, out_load[1]}, 32'd0);
        chk("R out_store", {31'd0, out_store[1]}, 32'd0);
        chk("R done", {31'd0, done[1]}, 32'd0);
        chk("R fwd_a_valid", {31'd0, fwd_a_valid[1]}, 32'd0);
        @(posedge clk); #1;
        rst_n[1] = 1'b1;
        #1;
        chk("R ready after release", {31'd0, ready[1]}, 32'd1);
        raddr_a[1] = 5'd0;
        @(posedge clk); #1;
        enq(1, WB_INSTR_OTHER, 5'd5, 32'h55, 1'b1, 32'h700, 32'h55, 1'b1);
        drain(1);

        @(posedge clk); #1;
        chk("scoreboard0 empty", exp_q0.size(), 32'd0);
        chk("scoreboard1 empty", exp_q1.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
